pwm_ramp_ctrl: RTL and testbench



---
 rtl/pwm_ramp_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty-cycle ramp sequencer: steps duty_out between MIN and MAX, one-shot or triangle.
// Optional build macro PWM_RAMP_DWELL_EN adds a DWELL register (0x0A) that holds duty at each limit in loop mode.
module pwm_ramp_ctrl #(
  parameter int TICK_BASE = 1024,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic [7:0]        duty_out,
  output logic              busy,
  output logic              limit_pulse,
  output logic              cfg_err
);

  localparam int              CW        = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam logic [CW-1:0]   BASE_LAST = CW'(TICK_BASE - 1);

  localparam logic [ADDR_W-1:0] A_DUTY     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_MIN      = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_MAX      = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_STEP     = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(9);
`ifdef PWM_RAMP_DWELL_EN
  localparam logic [ADDR_W-1:0] A_DWELL    = ADDR_W'(10);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DONE,
    S_DWELL
  } state_t;

  state_t      state;
  logic        ctrl_loop;
  logic        ctrl_dir;
  logic [7:0]  min_r;
  logic [7:0]  max_r;
  logic [7:0]  step_r;
  logic [7:0]  prescale_r;
  logic [CW-1:0] base_cnt;
  logic [7:0]  pre_cnt;
`ifdef PWM_RAMP_DWELL_EN
  logic [7:0]  dwell_r;
  logic [7:0]  dwell_cnt;
  logic        dwell_to_down;
`endif

  logic        running;
  logic        base_wrap;
  logic        tick;
  logic [7:0]  step_eff;
  logic [8:0]  sum_up;
  logic [8:0]  down_lim;

  assign running   = (state == S_UP) || (state == S_DOWN) || (state == S_DWELL);
  assign base_wrap = (base_cnt == BASE_LAST);
  // A write in the same cycle as a tick suppresses the step entirely.
  assign tick      = running && base_wrap && (pre_cnt >= prescale_r) && !cfg_wr;
  assign step_eff  = (step_r == 8'd0) ? 8'd1 : step_r;
  assign sum_up    = {1'b0, duty_out} + {1'b0, step_eff};
  assign down_lim  = {1'b0, min_r} + {1'b0, step_eff};

  // NOTE: every register here uses <= so all reads within the block see pre-edge values;
  // a later assignment in the same block overrides an earlier one (used for counter clears).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ctrl_loop   <= 1'b0;
      ctrl_dir    <= 1'b0;
      min_r       <= 8'd0;
      max_r       <= 8'd0;
      step_r      <= 8'd0;
      prescale_r  <= 8'd0;
      base_cnt    <= '0;
      pre_cnt     <= 8'd0;
      duty_out    <= 8'd0;
      busy        <= 1'b0;
      limit_pulse <= 1'b0;
      cfg_err     <= 1'b0;
`ifdef PWM_RAMP_DWELL_EN
      dwell_r       <= 8'd0;
      dwell_cnt     <= 8'd0;
      dwell_to_down <= 1'b0;
`endif
    end else begin
      limit_pulse <= 1'b0;

      if (!running) begin
        base_cnt <= '0;
        pre_cnt  <= 8'd0;
      end else if (base_wrap) begin
        base_cnt <= '0;
        pre_cnt  <= (pre_cnt >= prescale_r) ? 8'd0 : pre_cnt + 8'd1;
      end else begin
        base_cnt <= base_cnt + CW'(1);
      end

      if (cfg_wr) begin
        case (cfg_addr)
          A_DUTY: begin
            duty_out <= cfg_data;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end
          A_CTRL: begin
            ctrl_loop <= cfg_data[1];
            ctrl_dir  <= cfg_data[2];
            if (!cfg_data[0]) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              cfg_err <= 1'b0;
            end else if (state == S_IDLE || state == S_DONE) begin
              if (min_r > max_r) begin
                cfg_err <= 1'b1;
              end else begin
                cfg_err  <= 1'b0;
                base_cnt <= '0;
                pre_cnt  <= 8'd0;
                if (min_r == max_r) begin
                  duty_out    <= min_r;
                  state       <= S_DONE;
                  limit_pulse <= 1'b1;
                  busy        <= 1'b0;
                end else if (cfg_data[2]) begin
                  duty_out <= max_r;
                  state    <= S_DOWN;
                  busy     <= 1'b1;
                end else begin
                  duty_out <= min_r;
                  state    <= S_UP;
                  busy     <= 1'b1;
                end
              end
            end
          end
          A_MIN:      min_r      <= cfg_data;
          A_MAX:      max_r      <= cfg_data;
          A_STEP:     step_r     <= cfg_data;
          A_PRESCALE: prescale_r <= cfg_data;
`ifdef PWM_RAMP_DWELL_EN
          A_DWELL:    dwell_r    <= cfg_data;
`endif
          default: ;
        endcase
      end else if (tick) begin
        case (state)
          S_UP: begin
            if (sum_up >= {1'b0, max_r}) begin
              duty_out    <= max_r;
              limit_pulse <= 1'b1;
              if (!ctrl_loop) begin
                state <= S_DONE;
                busy  <= 1'b0;
`ifdef PWM_RAMP_DWELL_EN
              end else if (dwell_r != 8'd0) begin
                state         <= S_DWELL;
                dwell_cnt     <= dwell_r;
                dwell_to_down <= 1'b1;
`endif
              end else begin
                state <= S_DOWN;
              end
            end else begin
              duty_out <= sum_up[7:0];
            end
          end
          S_DOWN: begin
            if ({1'b0, duty_out} <= down_lim) begin
              duty_out    <= min_r;
              limit_pulse <= 1'b1;
              if (!ctrl_loop) begin
                state <= S_DONE;
                busy  <= 1'b0;
`ifdef PWM_RAMP_DWELL_EN
              end else if (dwell_r != 8'd0) begin
                state         <= S_DWELL;
                dwell_cnt     <= dwell_r;
                dwell_to_down <= 1'b0;
`endif
              end else begin
                state <= S_UP;
              end
            end else begin
              duty_out <= duty_out - step_eff;
            end
          end
`ifdef PWM_RAMP_DWELL_EN
          S_DWELL: begin
            if (dwell_cnt <= 8'd1) begin
              state <= dwell_to_down ? S_DOWN : S_UP;
            end else begin
              dwell_cnt <= dwell_cnt - 8'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl with TICK_BASE=4 (step every 4*(prescale+1) clocks).
module tb_pwm_ramp_ctrl;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [7:0]        cfg_data;
  logic [7:0]        duty_out;
  logic              busy;
  logic              limit_pulse;
  logic              cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_ramp_ctrl #(.TICK_BASE(4), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .duty_out    (duty_out),
    .busy        (busy),
    .limit_pulse (limit_pulse),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is captured on the next posedge and the task returns at the following negedge.
  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
    cfg_wr   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clk);
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_data = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] st, input logic [7:0] ps);
    wr(7'h06, mn);
    wr(7'h07, mx);
    wr(7'h08, st);
    wr(7'h09, ps);
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_data = 8'h00;
    cycles(3);
    check("rst_duty", duty_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_lp", limit_pulse, 0);
    check("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    cycles(1);

    // One-shot ramp 0x10 -> 0x40
    setup(8'h10, 8'h40, 8'h10, 8'h00);
    wr(7'h05, 8'h01);
    check("os_start", duty_out, 8'h10);
    check("os_busy", busy, 1);
    cycles(3);
    check("os_hold", duty_out, 8'h10);
    cycles(1);
    check("os_20", duty_out, 8'h20);
    cycles(4);
    check("os_30", duty_out, 8'h30);
    cycles(4);
    check("os_40", duty_out, 8'h40);
    check("os_lp", limit_pulse, 1);
    check("os_busy_lo", busy, 0);
    cycles(1);
    check("os_lp_lo", limit_pulse, 0);
    cycles(8);
    check("os_done_hold", duty_out, 8'h40);

    // Continuous triangle
    wr(7'h05, 8'h03);
    check("tri_start", duty_out, 8'h10);
    cycles(12);
    check("tri_40", duty_out, 8'h40);
    check("tri_lp_max", limit_pulse, 1);
    check("tri_busy", busy, 1);
    cycles(4);
    check("tri_30", duty_out, 8'h30);
    cycles(8);
    check("tri_10", duty_out, 8'h10);
    check("tri_lp_min", limit_pulse, 1);
    cycles(4);
    check("tri_20", duty_out, 8'h20);
    check("tri_busy2", busy, 1);
    wr(7'h05, 8'h00);
    check("stop_duty", duty_out, 8'h20);
    check("stop_busy", busy, 0);
    cycles(8);
    check("stop_hold", duty_out, 8'h20);

    // Full-range saturating ramp up then down
    setup(8'h00, 8'hFF, 8'h60, 8'h00);
    wr(7'h05, 8'h01);
    check("sat_00", duty_out, 8'h00);
    cycles(4);
    check("sat_60", duty_out, 8'h60);
    cycles(4);
    check("sat_C0", duty_out, 8'hC0);
    cycles(4);
    check("sat_FF", duty_out, 8'hFF);
    check("sat_lp", limit_pulse, 1);
    wr(7'h05, 8'h05);
    check("dn_FF", duty_out, 8'hFF);
    check("dn_busy", busy, 1);
    cycles(4);
    check("dn_9F", duty_out, 8'h9F);
    cycles(4);
    check("dn_3F", duty_out, 8'h3F);
    cycles(4);
    check("dn_00", duty_out, 8'h00);
    check("dn_lp", limit_pulse, 1);
    check("dn_busy_lo", busy, 0);

    // Direct duty write colliding with a tick
    setup(8'h10, 8'h40, 8'h10, 8'h00);
    wr(7'h05, 8'h01);
    cycles(8);
    check("col_30", duty_out, 8'h30);
    cycles(3);
    wr(7'h04, 8'h77);
    check("col_duty", duty_out, 8'h77);
    check("col_busy", busy, 0);
    check("col_lp", limit_pulse, 0);
    cycles(8);
    check("col_hold", duty_out, 8'h77);

    // MIN > MAX error
    wr(7'h06, 8'h50);
    wr(7'h07, 8'h20);
    wr(7'h05, 8'h01);
    check("err_set", cfg_err, 1);
    check("err_duty", duty_out, 8'h77);
    check("err_busy", busy, 0);
    cycles(5);
    check("err_sticky", cfg_err, 1);
    wr(7'h05, 8'h00);
    check("err_clr", cfg_err, 0);

    // Asynchronous reset mid-ramp
    setup(8'h10, 8'h40, 8'h10, 8'h00);
    wr(7'h05, 8'h03);
    cycles(5);
    check("pre_rst", duty_out, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_duty", duty_out, 8'h00);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(6);
    check("post_rst", duty_out, 8'h00);

    // STEP=0 acts as 1, PRESCALE=1 doubles the step period
    setup(8'h00, 8'h02, 8'h00, 8'h01);
    wr(7'h05, 8'h01);
    cycles(7);
    check("ps_hold", duty_out, 8'h00);
    cycles(1);
    check("ps_01", duty_out, 8'h01);
    cycles(8);
    check("ps_02", duty_out, 8'h02);
    check("ps_lp", limit_pulse, 1);
    check("ps_busy", busy, 0);

    // MIN == MAX start goes straight to DONE with a single pulse
    setup(8'h05, 8'h05, 8'h01, 8'h00);
    wr(7'h05, 8'h01);
    check("eq_duty", duty_out, 8'h05);
    check("eq_lp", limit_pulse, 1);
    check("eq_busy", busy, 0);
    cycles(1);
    check("eq_lp_lo", limit_pulse, 0);

`ifdef PWM_RAMP_DWELL_EN
    // Dwell of two ticks at each limit
    setup(8'h10, 8'h30, 8'h10, 8'h00);
    wr(7'h0A, 8'h02);
    wr(7'h05, 8'h03);
    cycles(8);
    check("dw_30", duty_out, 8'h30);
    cycles(11);
    check("dw_hold", duty_out, 8'h30);
    check("dw_busy", busy, 1);
    cycles(1);
    check("dw_20", duty_out, 8'h20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
